// File: rtl/ctrl_pkg.sv
// Shared control-unit definitions: field widths and control-ROM address layout.
package ctrl_pkg;

  localparam int unsigned OPCODE_W = 8;
  localparam int unsigned FLAGS_W  = 4;
  localparam int unsigned STEP_W   = 4;

  // Only the low three step bits reach the ROM address.
  localparam int unsigned STEP_ADDR_W = 3;

  // rom_addr field offsets (default widths)
  localparam int unsigned EXT_BIT    = 15;
  localparam int unsigned OPCODE_LSB = 7;
  localparam int unsigned FLAGS_LSB  = 3;
  localparam int unsigned STEP_LSB   = 0;

  typedef logic [STEP_W-1:0] step_t;

endpackage

// File: rtl/counter_161.sv
// 4-bit synchronous counter in the style of a '161: async clear, sync active-low
// load, CEP/CET count enables, ripple-carry TC. Advances on the falling clock edge.
module counter_161
  import ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  clr_n,
  input  logic  load_n,
  input  step_t d,
  input  logic  cep,
  input  logic  cet,
  output step_t q,
  output logic  tc
);

  // Count register: load has priority over counting; 15 wraps to 0 naturally.
  always_ff @(negedge clk or negedge clr_n) begin
    if (!clr_n)
      q <= '0;
    else if (!load_n)
      q <= d;
    else if (cep && cet)
      q <= q + step_t'(1);
  end

  // Terminal count qualified by CET only, as on the original part.
  always_comb begin
    tc = (q == '1) && cet;
  end

endmodule

// File: rtl/microstep_sequencer.sv
// Micro-step sequencer: step counter, extended-page flag and control-ROM address.
module microstep_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = ctrl_pkg::OPCODE_W,
  parameter int unsigned FLAGS_W  = ctrl_pkg::FLAGS_W
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic [OPCODE_W-1:0]                    opcode,
  input  logic [FLAGS_W-1:0]                     flags,
  input  logic                                   step_resetn,
  input  logic                                   step_extn,
  input  logic                                   ctrlen,
  output logic [STEP_W-1:0]                      step,
  output logic                                   step_tc,
  output logic                                   ext,
  output logic                                   ext_armn,
  output logic [1+OPCODE_W+FLAGS_W+STEP_ADDR_W-1:0] rom_addr
);

  // Step reset maps to the counter's sync load of zero; step_extn gates CEP so an
  // extend request freezes the count, and ctrlen gates CET so TC is masked too.
  counter_161 u_counter (
    .clk    (clk),
    .clr_n  (rstn),
    .load_n (step_resetn),
    .d      ('0),
    .cep    (step_extn),
    .cet    (~ctrlen),
    .q      (step),
    .tc     (step_tc)
  );

  // Extend latch: armed by step reset, cleared by an extend request, then sticky.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      ext_armn <= 1'b1;
    else
      ext_armn <= ~step_resetn | (step_extn & ext_armn);
  end

  // Page flag follows the latch half a cycle later, aligned with the step update.
  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn)
      ext <= 1'b0;
    else
      ext <= ~ext_armn;
  end

  // ROM address assembly, purely combinational.
  always_comb begin
    rom_addr = {ext, opcode, flags, step[STEP_ADDR_W-1:0]};
  end

endmodule

// File: tb/tb_microstep_sequencer.sv
// Directed bench for microstep_sequencer with an expectation queue.
module tb_microstep_sequencer;

  logic        clk;
  logic        rstn;
  logic [7:0]  opcode;
  logic [3:0]  flags;
  logic        step_resetn;
  logic        step_extn;
  logic        ctrlen;
  logic [3:0]  step;
  logic        step_tc;
  logic        ext;
  logic        ext_armn;
  logic [15:0] rom_addr;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  microstep_sequencer #(.OPCODE_W(8), .FLAGS_W(4)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .opcode      (opcode),
    .flags       (flags),
    .step_resetn (step_resetn),
    .step_extn   (step_extn),
    .ctrlen      (ctrlen),
    .step        (step),
    .step_tc     (step_tc),
    .ext         (ext),
    .ext_armn    (ext_armn),
    .rom_addr    (rom_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input string tag, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic check(input logic [15:0] obs);
    exp_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  // Falling edge is where step/ext update; sample 2 time units later.
  task automatic fall_cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic rise_cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rstn        = 1'b1;
    opcode      = 8'h00;
    flags       = 4'h0;
    step_resetn = 1'b1;
    step_extn   = 1'b1;
    ctrlen      = 1'b0;

    // 1: asynchronous reset between edges
    #7 rstn = 1'b0;
    push("rst_step", 16'h0); push("rst_ext", 16'h0);
    push("rst_armn", 16'h1); push("rst_tc", 16'h0);
    #1;
    check({12'h0, step}); check({15'h0, ext});
    check({15'h0, ext_armn}); check({15'h0, step_tc});
    fall_cyc();
    #1 rstn = 1'b1;
    push("rel_step", 16'h0);
    #1 check({12'h0, step});

    // 2: free count through a full wrap
    for (int unsigned i = 1; i <= 16; i++) begin
      push($sformatf("cnt_step_%0d", i), 16'(i % 16));
      push($sformatf("cnt_tc_%0d", i), (i % 16 == 15) ? 16'h1 : 16'h0);
    end
    for (int unsigned i = 1; i <= 16; i++) begin
      fall_cyc();
      check({12'h0, step});
      check({15'h0, step_tc});
    end
    push("cnt_ext", 16'h0); push("cnt_armn", 16'h1);
    check({15'h0, ext}); check({15'h0, ext_armn});

    // 3: ctrlen holds the count and masks TC
    repeat (5) fall_cyc();
    push("pre_hold_step", 16'h5);
    check({12'h0, step});
    ctrlen = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      push("hold_step", 16'h5); push("hold_tc", 16'h0);
    end
    for (int unsigned i = 0; i < 3; i++) begin
      fall_cyc();
      check({12'h0, step});
      check({15'h0, step_tc});
    end
    ctrlen = 1'b0;
    repeat (10) fall_cyc();
    push("at15_step", 16'hF); push("at15_tc", 16'h1);
    check({12'h0, step}); check({15'h0, step_tc});
    ctrlen = 1'b1;
    push("at15_masked_tc", 16'h0);
    #1 check({15'h0, step_tc});
    push("at15_hold_step", 16'hF); push("at15_hold_tc", 16'h0);
    fall_cyc();
    check({12'h0, step}); check({15'h0, step_tc});
    ctrlen = 1'b0;
    push("wrap_step", 16'h0);
    fall_cyc();
    check({12'h0, step});

    // 4: extend request at step 3
    repeat (3) fall_cyc();
    push("pre_ext_step", 16'h3);
    check({12'h0, step});
    step_extn = 1'b0;
    push("ext_armn_rise", 16'h0); push("ext_before_fall", 16'h0);
    rise_cyc();
    check({15'h0, ext_armn}); check({15'h0, ext});
    push("ext_step_frozen", 16'h3); push("ext_set", 16'h1); push("ext_addr", 16'h8003);
    fall_cyc();
    check({12'h0, step}); check({15'h0, ext}); check(rom_addr);
    step_extn = 1'b1;
    repeat (3) fall_cyc();
    push("page1_step", 16'h6); push("page1_ext", 16'h1);
    push("page1_armn", 16'h0); push("page1_addr", 16'h8006);
    check({12'h0, step}); check({15'h0, ext});
    check({15'h0, ext_armn}); check(rom_addr);

    // 5: step reset returns to page 0
    step_resetn = 1'b0;
    push("srst_armn", 16'h1); push("srst_ext_hold", 16'h1);
    rise_cyc();
    check({15'h0, ext_armn}); check({15'h0, ext});
    push("srst_step", 16'h0); push("srst_ext", 16'h0);
    fall_cyc();
    check({12'h0, step}); check({15'h0, ext});
    step_resetn = 1'b1;
    push("post_srst_step", 16'h1);
    fall_cyc();
    check({12'h0, step});

    // Simultaneous step reset and extend request: reset wins
    step_resetn = 1'b0;
    step_extn   = 1'b0;
    push("both_armn", 16'h1);
    rise_cyc();
    check({15'h0, ext_armn});
    push("both_step", 16'h0); push("both_ext", 16'h0);
    fall_cyc();
    check({12'h0, step}); check({15'h0, ext});
    step_resetn = 1'b1;
    step_extn   = 1'b1;
    push("after_both_step", 16'h1);
    fall_cyc();
    check({12'h0, step});

    // 6: address assembly, immediate response to opcode
    opcode = 8'hA5;
    flags  = 4'h9;
    push("addr_a5", 16'h52CA);
    fall_cyc();
    check(rom_addr);
    opcode = 8'h3C;
    push("addr_3c", 16'h1E4A);
    #1 check(rom_addr);

    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
